relprime_engine: RTL
====================

Name: relprime_engine

Overview:
- Parametrised hardware coprocessor: computes either relprime(n), the smallest m >= 2 with gcd(n, m) = 1, or gcd(a, b) of two operands.
- Sits beside the processor datapath as a memory/IO-mapped accelerator.
- Offloads the relprime software loop; start/busy/done handshake; width set by parameter.
- Uses one subtract-or-swap Euclid step per clock.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 4).

Ports:
- CLK  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high; returns block to IDLE.
- start  input  1  request; sampled only in IDLE.
- mode  input  1  0 = relprime(opA); 1 = gcd(opA, opB).
- opA  input  WIDTH  n (mode 0) or first operand (mode 1).
- opB  input  WIDTH  second operand (mode 1); ignored in mode 0.
- busy  output  1  high from cycle after accepted start until DONE.
- done  output  1  one-cycle pulse when result valid.
- result  output  WIDTH  answer; held until next accepted start.
- error  output  1  valid with done; relprime search overflowed.

Behaviour:
- Reset values: busy=0, done=0, result=0, error=0, state=IDLE. Reset mid-operation aborts immediately; no done pulse follows.
- Internal registers: mode_r, n_r, m (candidate), a, b (all WIDTH bits).

States:
- IDLE:
  - start=1 -> capture mode, opA, opB; clear result/error; go LOAD.
  - mode 0: n_r=opA, m=2.
  - start ignored in every other state.
- LOAD: a <= n_r, b <= m (mode 0) or a <= opA, b <= opB (mode 1); go STEP.
- STEP, one action per cycle:
  - b==0 -> g=a, go CHECK.
  - a<b -> swap a,b.
  - else a <= a-b.
- CHECK:
  - mode 1 -> result=g, go DONE.
  - mode 0, g==1 -> result=m, go DONE.
  - mode 0, otherwise m <= m+1. If m+1 wraps to 0 -> error=1, result=0, go DONE; else go LOAD.
- DONE: done=1 for exactly this cycle, busy=0; go IDLE. New start accepted from the following cycle.

Timing and width rules:
- busy=1 in LOAD, STEP, CHECK; 0 in IDLE and DONE.
- Latency is data-dependent but deterministic: 1 (LOAD) + steps + 1 (CHECK) per candidate, +1 DONE.
- Arithmetic is unsigned WIDTH-bit; a-b only when a>=b, so no underflow.

Boundary cases:
- gcd(0,0)=0; gcd(x,0)=x; gcd(0,x)=x after one swap.
- relprime(1)=2.
- relprime(0): gcd(0,m)=m is never 1, so the search overflows -> error=1, result=0.
- start held high through DONE: exactly one new operation begins, in the IDLE cycle after DONE.
- result/error stable while busy=0 until the next accepted start.

Test Plan:
- WIDTH=16, mode=0, opA=0x13B0 (5040), 1-cycle start -> exactly one done pulse, result=0x000B, error=0. busy high throughout, low in the done cycle.
- mode=1, opA=48, opB=18 -> result=6. Then opA=0, opB=0 -> result=0. Then opA=17, opB=0 -> result=17. Then opA=0, opB=9 -> result=9. All with error=0.
- mode=0, opA=1 -> result=2. opA=2 -> result=3. opA=30 -> result=7.
- WIDTH=8, mode=0, opA=0 -> done with error=1, result=0, within 256 candidate iterations. Then opA=0xFF -> result=2, error=0.
- Start pulsed while busy with different operands -> ignored; result matches the first request. start held high continuously -> back-to-back operations, one done per operation, at least one IDLE cycle between.
- reset asserted mid-STEP on a relprime(5040) run -> next cycle busy=0, done=0, result=0, state IDLE. A fresh start then yields 0x000B.

Source files
------------

// File: rtl/relprime_engine.sv
// relprime_engine: coprocessor that computes either relprime(n), the smallest
// m >= 2 with gcd(n, m) == 1, or gcd(a, b) of two operands.
// It performs one subtract-or-swap Euclid step per clock.
//
// Handshake: start is sampled only in IDLE. busy is high from the cycle after
// an accepted start through CHECK. done is a one-cycle pulse in DONE, and
// result/error are valid with it. result/error hold until the next accepted
// start clears them.
module relprime_engine #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             error,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_STEP  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state;
    logic             mode_r;
    logic [WIDTH-1:0] n_r;
    // Mode 0: m is the candidate being tested against n_r.
    // Mode 1: m holds the captured second operand, so LOAD is the same in both modes.
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    assign dbg_state = state;

    // Controller and Euclid datapath; every output is registered here.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            error  <= 1'b0;
            mode_r <= 1'b0;
            n_r    <= '0;
            m      <= '0;
            a      <= '0;
            b      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        mode_r <= mode;
                        n_r    <= opA;
                        m      <= mode ? opB : WIDTH'(2);
                        result <= '0;
                        error  <= 1'b0;
                        busy   <= 1'b1;
                        state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    a     <= n_r;
                    b     <= m;
                    state <= S_STEP;
                end
                S_STEP: begin
                    if (b == '0) begin
                        state <= S_CHECK;
                    end else if (a < b) begin
                        a <= b;
                        b <= a;
                    end else begin
                        a <= a - b;
                    end
                end
                S_CHECK: begin
                    // Here a holds the gcd, because b reached zero.
                    if (mode_r) begin
                        result <= a;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else if (a == WIDTH'(1)) begin
                        result <= m;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else if (m == {WIDTH{1'b1}}) begin
                        // The next candidate would wrap to zero, so the search has failed.
                        m      <= '0;
                        result <= '0;
                        error  <= 1'b1;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        m     <= m + WIDTH'(1);
                        state <= S_LOAD;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
